// File: rtl/axis_i2s2_tx.sv
// AXI-Stream stereo packets -> standard I2S (MCLK/LRCK/SCLK/SDOUT), one frame per 1024 clk.
// Latency: a packet completed before cnt==1023 plays in the next frame; tx_* lag the counter by 1 clk.
// Backpressure: s_axis_ready drops once the right word lands and returns after the frame load drains it.
module axis_i2s2_tx #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic                  tx_mclk,
  output logic                  tx_lrck,
  output logic                  tx_sclk,
  output logic                  tx_sdout,
  output logic                  underrun
);

  localparam logic [5:0] DW6 = 6'(DATA_WIDTH);

  logic [9:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] active_l_q, active_l_d;
  logic [DATA_WIDTH-1:0] active_r_q, active_r_d;
  logic                  have_l_q, have_l_d;
  logic                  have_r_q, have_r_d;
  logic                  primed_q, primed_d;
  logic                  underrun_q, underrun_d;
  logic                  ready_q, ready_d;
  logic                  mclk_q, mclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sclk_q, sclk_d;
  logic                  sdout_q, sdout_d;

  logic [4:0]            slot;
  logic [5:0]            bit_idx;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] sample_shift;
  logic                  in_word;
  logic                  hs;
  logic                  frame_end;
  logic                  full;

  // Free-running frame counter; all audio clocks are decoded from it.
  always_comb begin
    cnt_d = cnt_q + 10'd1;
  end

  // Decode the counter into the line clocks and the current serial data bit.
  // Slot 0 of each channel is the I2S one-bit delay, so the MSB lands in slot 1.
  always_comb begin
    slot         = cnt_q[8:4];
    sample       = cnt_q[9] ? active_r_q : active_l_q;
    bit_idx      = DW6 - {1'b0, slot};
    sample_shift = sample >> bit_idx;
    in_word      = (slot != 5'd0) && ({1'b0, slot} <= DW6);
    mclk_d       = cnt_q[0];
    sclk_d       = cnt_q[3];
    lrck_d       = cnt_q[9];
    sdout_d      = in_word & sample_shift[0];
  end

  // Holding buffer, frame load and underrun tracking.
  // The load only looks at registered flags, so a right word accepted in the
  // cnt==1023 cycle waits for the following frame.
  always_comb begin
    hs         = s_axis_valid & ready_q;
    frame_end  = (cnt_q == 10'd1023);
    full       = have_l_q & have_r_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    have_l_d   = have_l_q;
    have_r_d   = have_r_q;
    active_l_d = active_l_q;
    active_r_d = active_r_q;
    primed_d   = primed_q;
    underrun_d = underrun_q;
    if (frame_end) begin
      if (full) begin
        active_l_d = hold_l_q;
        active_r_d = hold_r_q;
        have_l_d   = 1'b0;
        have_r_d   = 1'b0;
        primed_d   = 1'b1;
      end else begin
        // Partial buffer is kept; the frame plays silence.
        active_l_d = '0;
        active_r_d = '0;
        if (primed_q) begin
          underrun_d = 1'b1;
        end
      end
    end
    if (hs) begin
      if (s_axis_last) begin
        hold_r_d = s_axis_data;
        have_r_d = 1'b1;
      end else begin
        hold_l_d = s_axis_data;
        have_l_d = 1'b1;
      end
    end
    ready_d = ~have_r_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      active_l_q <= '0;
      active_r_q <= '0;
      have_l_q   <= 1'b0;
      have_r_q   <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b1;
      mclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sdout_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      active_l_q <= active_l_d;
      active_r_q <= active_r_d;
      have_l_q   <= have_l_d;
      have_r_q   <= have_r_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      mclk_q     <= mclk_d;
      lrck_q     <= lrck_d;
      sclk_q     <= sclk_d;
      sdout_q    <= sdout_d;
    end
  end

  assign s_axis_ready = ready_q;
  assign tx_mclk      = mclk_q;
  assign tx_lrck      = lrck_q;
  assign tx_sclk      = sclk_q;
  assign tx_sdout     = sdout_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_axis_i2s2_tx.sv
// Self-checking bench for axis_i2s2_tx: frame-level model plus directed scenarios.
module tb_axis_i2s2_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready;
  logic        tx_mclk, tx_lrck, tx_sclk, tx_sdout, underrun;

  int checks = 0;
  int errors = 0;

  axis_i2s2_tx #(.DATA_WIDTH(24)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .tx_mclk(tx_mclk), .tx_lrck(tx_lrck), .tx_sclk(tx_sclk),
    .tx_sdout(tx_sdout), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position in frame since reset, holding buffer, and the 64 slot bits of the frame now playing.
  int          m_cnt = 0;
  int          m_last_p = -1;
  logic [23:0] m_hold_l, m_hold_r;
  bit          m_have_l, m_have_r, m_primed, m_underrun;
  bit          m_bits [64];
  bit          exp_mclk, exp_lrck, exp_sclk, exp_sdout;
  bit          model_live = 0;

  always @(posedge clk) begin
    int  p;
    bit  hs;
    model_live = 1;
    if (rst) begin
      m_cnt = 0; m_last_p = -1;
      m_hold_l = '0; m_hold_r = '0;
      m_have_l = 0; m_have_r = 0; m_primed = 0; m_underrun = 0;
      foreach (m_bits[i]) m_bits[i] = 0;
      exp_mclk = 0; exp_lrck = 0; exp_sclk = 0; exp_sdout = 0;
    end else begin
      p = m_cnt;
      m_last_p  = p;
      exp_mclk  = (p % 2) == 1;
      exp_sclk  = ((p / 8) % 2) == 1;
      exp_lrck  = p >= 512;
      exp_sdout = m_bits[p / 16];
      hs = s_axis_valid && !m_have_r;
      if (p == 1023) begin
        if (m_have_l && m_have_r) begin
          for (int s = 0; s < 32; s++) begin
            m_bits[s]      = (s >= 1 && s <= 24) ? m_hold_l[24 - s] : 1'b0;
            m_bits[32 + s] = (s >= 1 && s <= 24) ? m_hold_r[24 - s] : 1'b0;
          end
          m_have_l = 0; m_have_r = 0; m_primed = 1;
        end else begin
          foreach (m_bits[i]) m_bits[i] = 0;
          if (m_primed) m_underrun = 1;
        end
      end
      if (hs) begin
        if (s_axis_last) begin m_hold_r = s_axis_data; m_have_r = 1; end
        else             begin m_hold_l = s_axis_data; m_have_l = 1; end
      end
      m_cnt = (p + 1) % 1024;
    end
  end

  // ---------------- compare + frame capture ----------------
  logic [31:0] obs_l = '0, obs_r = '0, cap_l = '0, cap_r = '0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("mclk", tx_mclk, exp_mclk);
      chk("sclk", tx_sclk, exp_sclk);
      chk("lrck", tx_lrck, exp_lrck);
      chk("sdout", tx_sdout, exp_sdout);
      chk("ready", s_axis_ready, !m_have_r);
      chk("underrun", underrun, m_underrun);
      if (m_last_p >= 0) begin
        if ((m_last_p % 16) == 8) begin
          if (m_last_p < 512) obs_l[31 - (m_last_p / 16)] = tx_sdout;
          else                obs_r[31 - ((m_last_p - 512) / 16)] = tx_sdout;
        end
        if (m_last_p == 1023) begin
          cap_l = obs_l;
          cap_r = obs_r;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != p && n < 2100);
    if (m_cnt != p) begin
      errors++;
      $display("FAIL wait_pos timeout: at %0d expected %0d", m_cnt, p);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [23:0] d, input logic l);
    int n = 0;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    while (!s_axis_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_ready) begin
      errors++;
      $display("FAIL send timeout: ready %b expected 1", s_axis_ready);
    end
    @(negedge clk);
    s_axis_valid = 1'b0;
  endtask

  bit src_done = 0;
  logic [23:0] b2b_l [4] = '{24'h000001, 24'hFFFFFF, 24'hA5A5A5, 24'h5A5A5A};
  logic [23:0] b2b_r [4] = '{24'h800000, 24'h0F0F0F, 24'h123456, 24'hFEDCBA};

  initial begin
    int k;
    // Reset, then buffer a packet that a mid-frame reset must discard.
    repeat (4) @(negedge clk);
    chk("rst_ready", s_axis_ready, 1'b1);
    chk("rst_lrck", tx_lrck, 1'b0);
    rst = 1'b0;
    wait_pos(20);
    send(24'h123456, 1'b0);
    send(24'h654321, 1'b1);
    wait_pos(300);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_ready", s_axis_ready, 1'b1);
    chk("rst_mid_sdout", tx_sdout, 1'b0);
    chk("rst_mid_sclk", tx_sclk, 1'b0);
    chk("rst_mid_mclk", tx_mclk, 1'b0);
    chk("rst_mid_underrun", underrun, 1'b0);
    rst = 1'b0;
    // decode(512) is registered one clk later, so LRCK rises on the 513th edge.
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_lrck && k < 2000);
    chkw("lrck_first_rise", k, 513);
    wait_pos(1023); wait_pos(1);
    chkw("rst_frame0_l", cap_l, 32'h0);
    chkw("rst_frame0_r", cap_r, 32'h0);
    wait_pos(1023); wait_pos(1);
    chkw("rst_frame1_l", cap_l, 32'h0);
    chkw("rst_frame1_r", cap_r, 32'h0);
    chk("rst_no_underrun", underrun, 1'b0);

    // Single packet.
    send(24'h800001, 1'b0);
    send(24'h7FFFFF, 1'b1);
    chk("single_ready_low", s_axis_ready, 1'b0);
    wait_pos(1023);
    chk("single_ready_low_load", s_axis_ready, 1'b0);
    @(negedge clk);
    chk("single_ready_back", s_axis_ready, 1'b1);

    // Back-to-back source runs while the single packet plays.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(b2b_l[i], 1'b0);
          send(b2b_r[i], 1'b1);
        end
        src_done = 1;
      end
    join_none
    wait_pos(1023); wait_pos(1);
    chkw("single_l", cap_l, 32'h40000080);
    chkw("single_r", cap_r, 32'h3FFFFF80);
    k = 0;
    while (!src_done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done", src_done, 1'b1);
    chk("b2b_no_underrun", underrun, 1'b0);
    wait_pos(1023); wait_pos(1023); wait_pos(1);
    chkw("b2b_last_l", cap_l, 32'h2D2D2D00);
    chkw("b2b_last_r", cap_r, 32'h7F6E5D00);
    // Nothing queued for the next frame: underrun.
    chk("underrun_set", underrun, 1'b1);
    wait_pos(1023); wait_pos(1);
    chkw("underrun_frame_l", cap_l, 32'h0);
    chkw("underrun_frame_r", cap_r, 32'h0);

    // Overwrite of the left word.
    send(24'h111111, 1'b0);
    send(24'h222222, 1'b0);
    send(24'h333333, 1'b1);
    wait_pos(1023); wait_pos(1023); wait_pos(1);
    chkw("overwrite_l", cap_l, 32'h11111100);
    chkw("overwrite_r", cap_r, 32'h19999980);
    chk("underrun_sticky", underrun, 1'b1);

    // Right word accepted exactly at cnt==1023.
    send(24'hC00003, 1'b0);
    wait_pos(1023);
    chk("bnd_ready_at_1023", s_axis_ready, 1'b1);
    s_axis_data  = 24'h0000FF;
    s_axis_last  = 1'b1;
    s_axis_valid = 1'b1;
    @(negedge clk);
    s_axis_valid = 1'b0;
    chk("bnd_ready_low", s_axis_ready, 1'b0);
    wait_pos(512);
    chk("bnd_ready_low_mid", s_axis_ready, 1'b0);
    wait_pos(1023);
    chk("bnd_ready_low_end", s_axis_ready, 1'b0);
    wait_pos(1);
    chkw("bnd_silent_l", cap_l, 32'h0);
    chkw("bnd_silent_r", cap_r, 32'h0);
    chk("bnd_ready_back", s_axis_ready, 1'b1);
    wait_pos(1023); wait_pos(1);
    chkw("bnd_play_l", cap_l, 32'h60000180);
    chkw("bnd_play_r", cap_r, 32'h00007F80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
